ifu: RTL and testbench

Instruction fetch unit of the single-cycle MIPS core. Holds the architectural PC, fetches the word at PC from instruction memory over a req/ack handshake, and presents `pc`/`instr` to decode and next-address logic. It loads the `next_pc` computed downstream when the core commits the current instruction. It sits directly upstream of the next-address block and closes the PC loop.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_if.sv | 25 ++
 rtl/ifu_pc_check.sv | 18 +
 rtl/ifu.sv | 79 +++++++
 tb/tb_ifu.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared defaults and state encoding for the instruction fetch unit
package ifu_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_3000;
    localparam int          DEF_IMEM_AW   = 12;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_FAULT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - core-side and instruction-memory-side signals of the fetch unit
interface ifu_if #(
    parameter int IMEM_AW = ifu_pkg::DEF_IMEM_AW
);
    logic [31:0]        next_pc;
    logic               commit;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic               instr_valid;
    logic               fetch_fault;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;

    modport master (
        input  next_pc, commit, imem_ack, imem_rdata,
        output pc, instr, instr_valid, fetch_fault, imem_req, imem_addr
    );

    modport slave (
        output next_pc, commit, imem_ack, imem_rdata,
        input  pc, instr, instr_valid, fetch_fault, imem_req, imem_addr
    );
endinterface

// File: rtl/ifu_pc_check.sv
// rtl/ifu_pc_check.sv - alignment/range check of a byte address and its imem word index
module ifu_pc_check #(
    parameter logic [31:0] IMEM_BASE = ifu_pkg::DEF_IMEM_BASE,
    parameter int          IMEM_AW   = ifu_pkg::DEF_IMEM_AW
) (
    input  logic [31:0]        i_addr,
    output logic               o_legal,
    output logic [IMEM_AW-1:0] o_word_idx
);
    logic [31:0] w_offset;

    // Addresses below the base wrap to large offsets and fail the range test.
    assign w_offset = i_addr - IMEM_BASE;

    // The base is word aligned, so the offset's low bits equal the address's.
    assign o_legal    = (w_offset[1:0] == 2'b00) && (w_offset[31:IMEM_AW+2] == '0);
    assign o_word_idx = w_offset[IMEM_AW+1:2];
endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - PC register and fetch/hold/fault sequencer of the single-cycle MIPS core
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
    parameter int          IMEM_AW   = DEF_IMEM_AW
) (
    input  logic   clk,
    input  logic   reset,
    ifu_if.master  bus
);
    ifu_state_e         r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic               r_instr_valid;
    logic               r_fetch_fault;
    logic               w_next_legal;
    logic               w_pc_legal;
    logic [IMEM_AW-1:0] w_pc_idx;

    ifu_pc_check #(.IMEM_BASE(IMEM_BASE), .IMEM_AW(IMEM_AW)) u_next_check (
        .i_addr     (bus.next_pc),
        .o_legal    (w_next_legal),
        .o_word_idx ()
    );

    ifu_pc_check #(.IMEM_BASE(IMEM_BASE), .IMEM_AW(IMEM_AW)) u_pc_check (
        .i_addr     (r_pc),
        .o_legal    (w_pc_legal),
        .o_word_idx (w_pc_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (bus.commit) begin
                        r_pc          <= bus.next_pc;
                        r_instr_valid <= 1'b0;
                        if (w_next_legal) begin
                            r_state <= ST_FETCH;
                        end else begin
                            r_state       <= ST_FAULT;
                            r_fetch_fault <= 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    // The PC is always legal in FETCH; the extra gate only keeps a bad RESET_PC off the bus.
    assign bus.imem_req    = (r_state == ST_FETCH) && !reset && w_pc_legal;
    assign bus.imem_addr   = w_pc_idx;
    assign bus.pc          = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fetch_fault = r_fetch_fault;
endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed self-checking bench for the instruction fetch unit
module tb_ifu;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    ifu_if #(.IMEM_AW(12)) bus ();

    ifu #(
        .RESET_PC  (32'h0000_3000),
        .IMEM_BASE (32'h0000_3000),
        .IMEM_AW   (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fault(input string tag, input logic [31:0] bad_pc);
        check({tag, "_pc"},    bus.pc, bad_pc);
        check({tag, "_fault"}, {31'b0, bus.fetch_fault}, 32'd1);
        check({tag, "_req"},   {31'b0, bus.imem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.commit = 1'b0;
        bus.imem_ack = 1'b0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic fetch_ok(input logic [31:0] word);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word;
        step();
        bus.imem_ack = 1'b0;
    endtask

    task automatic commit_to(input logic [31:0] target);
        bus.commit = 1'b1;
        bus.next_pc = target;
        step();
        bus.commit = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b1;
        bus.commit = 1'b0;
        bus.next_pc = 32'h0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        step();
        step();
        check("req_in_reset", {31'b0, bus.imem_req}, 32'd0);
        reset = 1'b0;
        #1;

        check("rst_pc",    bus.pc, 32'h0000_3000);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst_fault", {31'b0, bus.fetch_fault}, 32'd0);
        check("rst_req",   {31'b0, bus.imem_req}, 32'd1);
        check("rst_addr",  {20'b0, bus.imem_addr}, 32'd0);

        fetch_ok(32'h3C01_0001);
        check("f0_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("f0_instr", bus.instr, 32'h3C01_0001);
        check("f0_req",   {31'b0, bus.imem_req}, 32'd0);

        commit_to(32'h0000_3004);
        check("c1_pc",    bus.pc, 32'h0000_3004);
        check("c1_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("c1_instr_held", bus.instr, 32'h3C01_0001);
        check("w_req_1",  {31'b0, bus.imem_req}, 32'd1);
        check("w_addr_1", {20'b0, bus.imem_addr}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check($sformatf("w_req_%0d", i),  {31'b0, bus.imem_req}, 32'd1);
            check($sformatf("w_addr_%0d", i), {20'b0, bus.imem_addr}, 32'd1);
            check($sformatf("w_valid_%0d", i), {31'b0, bus.instr_valid}, 32'd0);
        end
        fetch_ok(32'h8C22_0004);
        check("f1_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("f1_instr", bus.instr, 32'h8C22_0004);

        commit_to(32'h0000_3008);
        bus.commit = 1'b1;
        bus.next_pc = 32'h0000_3100;
        step();
        check("cf_pc_a", bus.pc, 32'h0000_3008);
        step();
        check("cf_pc_b", bus.pc, 32'h0000_3008);
        check("cf_req",  {31'b0, bus.imem_req}, 32'd1);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h2442_0001;
        step();
        bus.imem_ack = 1'b0;
        bus.commit = 1'b0;
        check("cf_pc_c",  bus.pc, 32'h0000_3008);
        check("cf_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("cf_instr", bus.instr, 32'h2442_0001);

        commit_to(32'h0000_6FFC);
        check("last_pc",    bus.pc, 32'h0000_6FFC);
        check("last_addr",  {20'b0, bus.imem_addr}, 32'd4095);
        check("last_req",   {31'b0, bus.imem_req}, 32'd1);
        check("last_fault", {31'b0, bus.fetch_fault}, 32'd0);
        fetch_ok(32'h0000_000C);
        check("last_valid", {31'b0, bus.instr_valid}, 32'd1);

        commit_to(32'h0000_3002);
        check_fault("misal", 32'h0000_3002);
        bus.commit = 1'b1;
        bus.next_pc = 32'h0000_3000;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        bus.commit = 1'b0;
        bus.imem_ack = 1'b0;
        check_fault("misal_hold", 32'h0000_3002);
        check("misal_instr", bus.instr, 32'h0000_000C);

        do_reset();
        fetch_ok(32'h1111_1111);
        commit_to(32'h0000_2FFC);
        check_fault("below", 32'h0000_2FFC);

        do_reset();
        fetch_ok(32'h2222_2222);
        commit_to(32'h0000_7000);
        check_fault("above", 32'h0000_7000);

        do_reset();
        fetch_ok(32'h3333_3333);
        commit_to(32'h0000_3004);
        check("rmid_pre_pc", bus.pc, 32'h0000_3004);
        reset = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h4444_4444;
        bus.commit = 1'b1;
        bus.next_pc = 32'h0000_3010;
        #1;
        check("rmid_req_drop", {31'b0, bus.imem_req}, 32'd0);
        step();
        reset = 1'b0;
        bus.imem_ack = 1'b0;
        bus.commit = 1'b0;
        #1;
        check("rmid_pc",    bus.pc, 32'h0000_3000);
        check("rmid_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rmid_fault", {31'b0, bus.fetch_fault}, 32'd0);
        check("rmid_req",   {31'b0, bus.imem_req}, 32'd1);
        check("rmid_instr", bus.instr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
